// File: rtl/mod_74x163_3.sv
// mod_74x163_3: cascade of STAGES 74x163-style 4-bit synchronous counters with ripple carry.
module mod_74x163_3 #(
  parameter int STAGES = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LD_N,
  input  logic                  ENP,
  input  logic                  ENT,
  input  logic [4*STAGES-1:0]   D,
  output logic [4*STAGES-1:0]   Q,
  output logic [STAGES-1:0]     RCO_S,
  output logic                  RCO
);
  logic [4*STAGES-1:0] nxt;
  logic c;
  always_comb begin
    nxt = Q;
    RCO_S = '0;
    c = ENT;
    for (int i = 0; i < STAGES; i++) begin
      nxt[4*i+:4] = (ENP & c) ? Q[4*i+:4] + 4'd1 : Q[4*i+:4];
      c = c & (&Q[4*i+:4]);
      RCO_S[i] = c;
    end
  end
  assign RCO = RCO_S[STAGES-1];
  always_ff @(posedge CLK)
    Q <= RST ? '0 : !LD_N ? D : nxt;
endmodule

// File: tb/tb_mod_74x163_3.sv
// tb_mod_74x163_3: vector table plus scoreboarded sequences against a whole-chain counter model.
module tb_mod_74x163_3;
  localparam int S = 3;
  localparam int W = 4 * S;
  logic CLK = 1'b0;
  logic RST = 1'b0, LD_N = 1'b1, ENP = 1'b0, ENT = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q;
  logic [S-1:0] RCO_S;
  logic RCO;
  logic [2:0] y;
  mod_74x163_3 #(.STAGES(S)) dut (
    .CLK(CLK), .RST(RST), .LD_N(LD_N), .ENP(ENP), .ENT(ENT),
    .D(D), .Q(Q), .RCO_S(RCO_S), .RCO(RCO)
  );
  always #5 CLK = ~CLK;
  // Downstream 3-wide AND stage fed by the low two octal digits of the count
  assign y = Q[2:0] & Q[5:3];
  typedef struct {
    logic rst, ld_n, enp, ent;
    logic [W-1:0] d, q;
    logic [S-1:0] rs;
  } vec_t;
  typedef struct {
    logic [W-1:0] q;
    logic [S-1:0] rs;
    string name;
  } exp_t;
  exp_t sb[$];
  vec_t v[22];
  int checks = 0, errors = 0;
  logic [W-1:0] mq = '0;
  function automatic logic [S-1:0] mrco(input logic [W-1:0] q, input logic t);
    logic [W-1:0] m;
    mrco = '0;
    for (int k = 0; k < S; k++) begin
      m = W'((1 << (4*k+4)) - 1);
      mrco[k] = t && ((q & m) == m);
    end
  endfunction
  task automatic check(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(input logic rst, ld, p, t, input logic [W-1:0] d,
                       input logic [W-1:0] eq, input logic [S-1:0] ers, input string n);
    exp_t e;
    RST = rst; LD_N = ld; ENP = p; ENT = t; D = d;
    sb.push_back('{eq, ers, n});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check({e.name, "_q"}, Q, e.q);
    check({e.name, "_rco_s"}, W'(RCO_S), W'(e.rs));
    check({e.name, "_rco"}, W'(RCO), W'(e.rs[S-1]));
    mq = e.q;
  endtask
  task automatic step(input logic rst, ld, p, t, input logic [W-1:0] d, input string n);
    logic [W-1:0] nq;
    nq = rst ? '0 : !ld ? d : (p & t) ? mq + 1'b1 : mq;
    drive(rst, ld, p, t, d, nq, mrco(nq, t), n);
  endtask
  initial begin
    v[0]  = '{1,1,0,0,12'h000,12'h000,3'b000};
    v[1]  = '{0,0,0,0,12'h5A3,12'h5A3,3'b000};
    v[2]  = '{1,0,0,0,12'hFFF,12'h000,3'b000};
    v[3]  = '{0,0,1,1,12'h00E,12'h00E,3'b000};
    v[4]  = '{0,1,1,1,12'h000,12'h00F,3'b001};
    v[5]  = '{0,1,1,1,12'h000,12'h010,3'b000};
    v[6]  = '{0,0,1,1,12'hFFE,12'hFFE,3'b000};
    v[7]  = '{0,1,1,1,12'h000,12'hFFF,3'b111};
    v[8]  = '{0,1,1,1,12'h000,12'h000,3'b000};
    v[9]  = '{0,0,0,1,12'h0FF,12'h0FF,3'b011};
    v[10] = '{0,1,0,1,12'h000,12'h0FF,3'b011};
    v[11] = '{0,1,0,1,12'h000,12'h0FF,3'b011};
    v[12] = '{0,1,0,1,12'h000,12'h0FF,3'b011};
    v[13] = '{0,1,0,0,12'h000,12'h0FF,3'b000};
    v[14] = '{0,1,1,0,12'h000,12'h0FF,3'b000};
    v[15] = '{1,0,1,1,12'h123,12'h000,3'b000};
    v[16] = '{0,0,1,1,12'h123,12'h123,3'b000};
    v[17] = '{0,1,1,1,12'h000,12'h124,3'b000};
    v[18] = '{1,1,1,1,12'h000,12'h000,3'b000};
    v[19] = '{0,1,1,1,12'h000,12'h001,3'b000};
    v[20] = '{0,0,0,0,12'h7F0,12'h7F0,3'b000};
    v[21] = '{0,0,1,1,12'h0F0,12'h0F0,3'b000};
    #2;
    for (int i = 0; i < 22; i++)
      drive(v[i].rst, v[i].ld_n, v[i].enp, v[i].ent, v[i].d, v[i].q, v[i].rs, $sformatf("vec%0d", i));
    step(0, 0, 0, 0, 12'h5A5, "preload");
    RST = 1'b1;
    #3;
    check("rst_before_edge", Q, mq);
    step(1, 1, 1, 1, 12'h000, "rst_edge");
    check("and_y_0", W'(y), W'(mq[2:0] & mq[5:3]));
    for (int i = 1; i < 64; i++) begin
      step(0, 1, 1, 1, 12'h000, $sformatf("cnt%0d", i));
      check($sformatf("and_y_%0d", i), W'(y), W'(mq[2:0] & mq[5:3]));
    end
    step(0, 0, 1, 1, 12'hEFE, "ld_efe");
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 1, 12'h000, $sformatf("mid_wrap%0d", i));
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, W'($urandom), $sformatf("rnd%0d", i));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
